// File: rtl/des_pkg.sv
// Shared types for the DES block collector: block type, serialiser states
// and the per-byte odd-parity helper.
package des_pkg;

  localparam int DES_BLOCK_W = 64;

  typedef logic [DES_BLOCK_W-1:0] des_block_t;

  typedef enum logic [0:0] {
    COL_IDLE  = 1'b0,
    COL_SHIFT = 1'b1
  } col_state_t;

  // Bit i is the odd-parity bit of byte i, where byte 0 is the most significant byte.
  function automatic logic [7:0] odd_parity_bytes(input des_block_t d);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p[i] = ~^d[DES_BLOCK_W-1-8*i -: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/des_sync_fifo.sv
// Synchronous FIFO of 64-bit DES blocks with first-word fall-through read.
// An extra count bit separates full from empty; pointers wrap modulo DEPTH.
module des_sync_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_push,
  input  des_block_t i_data,
  input  logic       i_pop,
  output des_block_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  des_block_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_pop;
  logic           w_do_push;

  // A push at full is only legal when the same edge frees a slot.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/des_block_collector.sv
// Buffers DES output blocks and serialises them MSB chunk first on a valid/ready stream.
// Optional per-byte odd parity on the output word with DES_COLLECTOR_PARITY_EN.
module des_block_collector
  import des_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_blk_valid,
  input  des_block_t             i_blk_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
`ifdef DES_COLLECTOR_PARITY_EN
  output logic [OUT_WIDTH+OUT_WIDTH/8-1:0] o_out_data,
  output logic [OUT_WIDTH/8-1:0] o_out_parity,
`else
  output logic [OUT_WIDTH-1:0]   o_out_data,
`endif
  output logic                   o_out_last,
  output logic                   o_fifo_full,
  output logic                   o_overflow,
  input  logic                   i_clear_ovf,
  output logic                   o_busy
);

  localparam int NBEATS = DES_BLOCK_W / OUT_WIDTH;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  col_state_t    r_state;
  des_block_t    r_shift;
  logic [BW-1:0] r_beat;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_overflow;

  des_block_t    w_fifo_data;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_hs;
  logic          w_pop;
  logic          w_push;

  assign w_hs   = r_out_valid & i_out_ready;
  // Refill from the FIFO when idle or on the last-beat handshake, so blocks stream back to back.
  assign w_pop  = ~w_fifo_empty & ((r_state == COL_IDLE) | (w_hs & r_out_last));
  assign w_push = i_blk_valid & (~w_fifo_full | w_pop);

  des_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_data  (i_blk_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= COL_IDLE;
      r_shift     <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        COL_IDLE: begin
          if (w_pop) begin
            r_state     <= COL_SHIFT;
            r_shift     <= w_fifo_data;
            r_beat      <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (NBEATS == 1);
          end
        end
        COL_SHIFT: begin
          if (w_hs) begin
            if (r_out_last) begin
              if (w_pop) begin
                r_shift     <= w_fifo_data;
                r_beat      <= '0;
                r_out_last  <= (NBEATS == 1);
              end else begin
                r_state     <= COL_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
              end
            end else begin
              r_shift    <= r_shift << OUT_WIDTH;
              r_beat     <= r_beat + 1'b1;
              r_out_last <= (r_beat == LAST_BEAT - 1'b1);
            end
          end
        end
        default: begin
          r_state     <= COL_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  // A drop sets the sticky flag even if the host clears in the same cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_overflow <= 1'b0;
    end else if (i_blk_valid & w_fifo_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end else if (i_clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef DES_COLLECTOR_PARITY_EN
  logic [7:0]             w_par_all;
  logic [OUT_WIDTH/8-1:0] w_parity;

  assign w_par_all    = odd_parity_bytes(r_shift);
  assign w_parity     = {(OUT_WIDTH/8){r_out_valid}} & w_par_all[OUT_WIDTH/8-1:0];
  assign o_out_data   = {r_shift[DES_BLOCK_W-1 -: OUT_WIDTH], w_parity};
  assign o_out_parity = w_parity;
`else
  assign o_out_data   = r_shift[DES_BLOCK_W-1 -: OUT_WIDTH];
`endif

  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_overflow  = r_overflow;
  assign o_fifo_full = w_fifo_full;
  assign o_busy      = ~w_fifo_empty | (r_state == COL_SHIFT);

endmodule

// File: tb/tb_des_block_collector.sv
// Directed bench for des_block_collector (OUT_WIDTH=8, FIFO_DEPTH=4) with an
// expected-word scoreboard checked on every output handshake.
module tb_des_block_collector;

  localparam int W = 8;
`ifdef DES_COLLECTOR_PARITY_EN
  localparam int DW = W + W/8;
`else
  localparam int DW = W;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          blk_valid;
  logic [63:0]   blk_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          fifo_full;
  logic          overflow;
  logic          clear_ovf;
  logic          busy;
`ifdef DES_COLLECTOR_PARITY_EN
  logic [W/8-1:0] out_parity;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  des_block_collector #(
    .FIFO_DEPTH (4),
    .OUT_WIDTH  (W)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_blk_valid (blk_valid),
    .i_blk_data  (blk_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
`ifdef DES_COLLECTOR_PARITY_EN
    .o_out_parity(out_parity),
`endif
    .o_out_last  (out_last),
    .o_fifo_full (fifo_full),
    .o_overflow  (overflow),
    .i_clear_ovf (clear_ovf),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [63:0] b);
    for (int i = 0; i < 8; i++) begin
      q.push_back({b[63-8*i -: 8], (i == 7)});
    end
  endtask

  task automatic strobe(input logic [63:0] b, input bit accept);
    blk_valid = 1'b1;
    blk_data  = b;
    if (accept) push_block(b);
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < 300), 64'd1);
  endtask

  // Scoreboard: a word is consumed at the next edge whenever valid & ready hold here.
  always @(negedge clk) begin
    exp_t e;
    if (nrst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        assert (1'b0) else begin
          errors++;
          $error("FAIL unexpected_word observed %h expected none", out_data[DW-1 -: W]);
        end
      end else begin
        e = q.pop_front();
        chk("word", 64'(out_data[DW-1 -: W]), 64'(e.d));
        chk("last", 64'(out_last), 64'(e.l));
`ifdef DES_COLLECTOR_PARITY_EN
        chk("parity", 64'(out_parity), 64'(~^e.d));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nrst      = 1'b0;
    blk_valid = 1'b0;
    blk_data  = 64'd0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_full",  64'(fifo_full), 64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    tick();
    nrst = 1'b1;
    tick();

    // Basic serialisation and two-edge latency
    out_ready = 1'b1;
    strobe(64'h0123456789ABCDEF, 1'b1);
    chk("lat_valid_e0", 64'(out_valid), 64'd0);
    chk("lat_busy_e0",  64'(busy),      64'd1);
    tick();
    chk("lat_valid_e1", 64'(out_valid), 64'd1);
    chk("lat_word0",    64'(out_data[DW-1 -: W]), 64'h01);
    wait_drain();

    // Stall after the first beat is taken: 0x23 must be held
    out_ready = 1'b0;
    strobe(64'h0123456789ABCDEF, 1'b1);
    tick();
    chk("stall_pre", 64'(out_data[DW-1 -: W]), 64'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data",  64'(out_data[DW-1 -: W]), 64'h23);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    wait_drain();

    // Burst of six with no consumer: five kept, sixth dropped
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      strobe(64'h0F1E2D3C4B5A6978 ^ {8{8'(k)}}, 1'b1);
    end
    chk("burst_full",     64'(fifo_full), 64'd1);
    chk("burst_ovf_pre",  64'(overflow),  64'd0);
    strobe(64'hDEADBEEFCAFEF00D, 1'b0);
    chk("burst_ovf_set",  64'(overflow),  64'd1);
    chk("burst_full_hold", 64'(fifo_full), 64'd1);
    out_ready = 1'b1;
    wait_drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Write coincident with last-beat handshake while full
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      strobe(64'h8877665544332211 + 64'(k), 1'b1);
    end
    chk("coin_full_pre", 64'(fifo_full), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_last) && n < 50) begin
      tick();
      n++;
    end
    chk("coin_found_last", 64'(n < 50), 64'd1);
    blk_valid = 1'b1;
    blk_data  = 64'h5A5AA5A5C3C33C3C;
    push_block(64'h5A5AA5A5C3C33C3C);
    tick();
    blk_valid = 1'b0;
    chk("coin_ovf",  64'(overflow),  64'd0);
    chk("coin_full", 64'(fifo_full), 64'd1);
    wait_drain();

    // Asynchronous reset in the middle of a block
    out_ready = 1'b1;
    strobe(64'hFEDCBA9876543210, 1'b1);
    tick();
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_last",  64'(out_last),  64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    chk("mid_rst_full",  64'(fifo_full), 64'd0);
    q.delete();
    tick();
    nrst = 1'b1;
    strobe(64'h00FF01FE02FD03FC, 1'b1);
    wait_drain();
    chk("post_rst_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
